// File: rtl/wb_select_pipe.sv
`default_nettype none
// ============================================================================
// wb_select_pipe : KGP-RISC write-back select, load extension, 2-entry skid.
// Optional forwarding ports: define WB_FWD_BYPASS_EN.        Revision: 1.0
// ============================================================================
module wb_select_pipe #(
  parameter int DATA_W  = 32,
  parameter int NUM_SRC = 4,
  parameter int SEL_W   = 2,
  parameter int RA_W    = 5,
  parameter int MEM_SRC = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [NUM_SRC*DATA_W-1:0] src_data,
  input  logic [SEL_W-1:0]          mem_to_reg,
  input  logic [1:0]                ld_size,
  input  logic                      ld_signed,
  input  logic [1:0]                ld_off,
  input  logic [RA_W-1:0]           in_rd,
  input  logic                      in_we,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_W-1:0]         out_data,
  output logic [RA_W-1:0]           out_rd,
  output logic                      out_we
`ifdef WB_FWD_BYPASS_EN
  ,
  output logic                      fwd_valid,
  output logic [RA_W-1:0]           fwd_rd,
  output logic [DATA_W-1:0]         fwd_data,
  output logic                      fwd_we
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] head_data_q, head_data_d;
  logic [RA_W-1:0]   head_rd_q, head_rd_d;
  logic              head_we_q, head_we_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic [RA_W-1:0]   skid_rd_q, skid_rd_d;
  logic              skid_we_q, skid_we_d;

  logic [DATA_W-1:0] sel_data;
  logic [31:0]       ld_word;
  logic [7:0]        ld_byte;
  logic [15:0]       ld_half;
  logic [DATA_W-1:0] word_ext;
  logic [DATA_W-1:0] ext_data;
  logic [DATA_W-1:0] proc_data;
  logic              proc_we;
  logic              in_fire;
  logic              out_fire;

  // Source select; any out-of-range code falls back to source 0 (ALU).
  always_comb begin
    sel_data = src_data[DATA_W-1:0];
    for (int k = 1; k < NUM_SRC; k++) begin
      if (int'(mem_to_reg) == k) begin
        sel_data = src_data[k*DATA_W +: DATA_W];
      end
    end
  end

  assign ld_word = sel_data[31:0];

  always_comb begin
    case (ld_off)
      2'd0:    ld_byte = ld_word[7:0];
      2'd1:    ld_byte = ld_word[15:8];
      2'd2:    ld_byte = ld_word[23:16];
      default: ld_byte = ld_word[31:24];
    endcase
    ld_half = ld_off[1] ? ld_word[31:16] : ld_word[15:0];
  end

  generate
    if (DATA_W > 32) begin : g_word_wide
      assign word_ext = {{(DATA_W-32){ld_signed & ld_word[31]}}, ld_word};
    end else begin : g_word_native
      assign word_ext = ld_word;
    end
  endgenerate

  always_comb begin
    case (ld_size)
      2'b00:   ext_data = {{(DATA_W-8){ld_signed & ld_byte[7]}}, ld_byte};
      2'b01:   ext_data = {{(DATA_W-16){ld_signed & ld_half[15]}}, ld_half};
      default: ext_data = word_ext;
    endcase
  end

  assign proc_data = (int'(mem_to_reg) == MEM_SRC) ? ext_data : sel_data;
  assign proc_we   = in_we & (in_rd != '0);

  // in_ready is a function of registered state and flush only.
  assign in_ready  = (state_q != FULL) & ~flush;
  assign out_valid = (state_q != EMPTY);
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  assign out_data = head_data_q;
  assign out_rd   = head_rd_q;
  assign out_we   = head_we_q;

  always_comb begin
    state_d     = state_q;
    head_data_d = head_data_q;
    head_rd_d   = head_rd_q;
    head_we_d   = head_we_q;
    skid_data_d = skid_data_q;
    skid_rd_d   = skid_rd_q;
    skid_we_d   = skid_we_q;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_fire) begin
            head_data_d = proc_data;
            head_rd_d   = in_rd;
            head_we_d   = proc_we;
            state_d     = ONE;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            head_data_d = proc_data;
            head_rd_d   = in_rd;
            head_we_d   = proc_we;
          end else if (in_fire) begin
            skid_data_d = proc_data;
            skid_rd_d   = in_rd;
            skid_we_d   = proc_we;
            state_d     = FULL;
          end else if (out_fire) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (out_fire) begin
            head_data_d = skid_data_q;
            head_rd_d   = skid_rd_q;
            head_we_d   = skid_we_q;
            state_d     = ONE;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= EMPTY;
      head_data_q <= '0;
      head_rd_q   <= '0;
      head_we_q   <= 1'b0;
      skid_data_q <= '0;
      skid_rd_q   <= '0;
      skid_we_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      head_data_q <= head_data_d;
      head_rd_q   <= head_rd_d;
      head_we_q   <= head_we_d;
      skid_data_q <= skid_data_d;
      skid_rd_q   <= skid_rd_d;
      skid_we_q   <= skid_we_d;
    end
  end

`ifdef WB_FWD_BYPASS_EN
  // Youngest stored entry: the skid slot when FULL, otherwise the head.
  always_comb begin
    fwd_valid = 1'b0;
    fwd_rd    = '0;
    fwd_data  = '0;
    fwd_we    = 1'b0;
    if (state_q == FULL) begin
      fwd_valid = 1'b1;
      fwd_rd    = skid_rd_q;
      fwd_data  = skid_data_q;
      fwd_we    = skid_we_q;
    end else if (state_q == ONE) begin
      fwd_valid = 1'b1;
      fwd_rd    = head_rd_q;
      fwd_data  = head_data_q;
      fwd_we    = head_we_q;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_wb_select_pipe.sv
`default_nettype none
// ============================================================================
// tb_wb_select_pipe : directed bench with a queue-based reference model.
// Revision: 1.0
// ============================================================================
module tb_wb_select_pipe;

  localparam int DATA_W  = 32;
  localparam int NUM_SRC = 3;
  localparam int SEL_W   = 2;
  localparam int RA_W    = 5;
  localparam int MEM_SRC = 2;

  typedef struct {
    logic [31:0] d;
    logic [4:0]  rd;
    logic        we;
  } entry_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [31:0] s0 = '0, s1 = '0, s2 = '0;
  logic [95:0] src_bus;
  logic [1:0]  sel = '0, size = 2'b10, off = '0;
  logic        sgn = 1'b0, we = 1'b0;
  logic [4:0]  rd = '0;
  logic        in_ready, out_valid, out_we;
  logic [31:0] out_data;
  logic [4:0]  out_rd;
`ifdef WB_FWD_BYPASS_EN
  logic        fwd_valid, fwd_we;
  logic [4:0]  fwd_rd;
  logic [31:0] fwd_data;
`endif

  assign src_bus = {s2, s1, s0};

  wb_select_pipe #(
    .DATA_W(DATA_W), .NUM_SRC(NUM_SRC), .SEL_W(SEL_W), .RA_W(RA_W), .MEM_SRC(MEM_SRC)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .src_data(src_bus),
    .mem_to_reg(sel), .ld_size(size), .ld_signed(sgn), .ld_off(off),
    .in_rd(rd), .in_we(we),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_rd(out_rd), .out_we(out_we)
`ifdef WB_FWD_BYPASS_EN
    , .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data), .fwd_we(fwd_we)
`endif
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    else n_pass++;
  endtask

  // Expected entry from the architectural rules, using integer arithmetic.
  function automatic entry_t model_entry();
    entry_t e;
    logic [31:0] raw;
    int v;
    int s;
    s = (int'(sel) < NUM_SRC) ? int'(sel) : 0;
    raw = src_bus[s*32 +: 32];
    if (int'(sel) == MEM_SRC) begin
      case (size)
        2'b00: begin
          v = int'((raw >> (8 * int'(off))) & 32'hFF);
          if (sgn && v > 127) v -= 256;
        end
        2'b01: begin
          v = int'((raw >> (16 * int'(off[1]))) & 32'hFFFF);
          if (sgn && v > 32767) v -= 65536;
        end
        default: v = int'(raw);
      endcase
      e.d = 32'(v);
    end else begin
      e.d = raw;
    end
    e.rd = rd;
    e.we = we && (rd != 5'd0);
    return e;
  endfunction

  entry_t mq[$];

  always @(posedge clk or posedge rst) begin
    bit ifire;
    bit ofire;
    if (rst) begin
      mq.delete();
    end else begin
      ifire = in_valid && (mq.size() < 2) && !flush;
      ofire = (mq.size() > 0) && out_ready;
      if (flush) begin
        mq.delete();
      end else begin
        if (ofire) void'(mq.pop_front());
        if (ifire) mq.push_back(model_entry());
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("cmp_in_ready", 32'(in_ready), 32'((mq.size() < 2) && !flush));
      chk("cmp_out_valid", 32'(out_valid), 32'(mq.size() != 0));
      if (mq.size() != 0) begin
        chk("cmp_out_data", out_data, mq[0].d);
        chk("cmp_out_rd", 32'(out_rd), 32'(mq[0].rd));
        chk("cmp_out_we", 32'(out_we), 32'(mq[0].we));
      end
    end
  end

  bit          cap_en = 1'b0;
  logic [31:0] seen[$];
  always @(negedge clk) begin
    if (cap_en && out_valid && out_ready) seen.push_back(out_data);
  end

  task automatic one(input logic [1:0] s, input logic [1:0] sz, input logic sg,
                     input logic [1:0] o, input logic [4:0] r, input logic w);
    @(posedge clk); #1;
    sel = s; size = sz; sgn = sg; off = o; rd = r; we = w; in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
  endtask

  logic [1:0]  t2_sz  [8] = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b01, 2'b00, 2'b11, 2'b00};
  logic        t2_sg  [8] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
  logic [1:0]  t2_off [8] = '{2'd0, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3, 2'd0, 2'd1};
  logic [31:0] t2_exp [8] = '{32'h0000_007F, 32'hFFFF_FFF0, 32'h0000_8000, 32'hFFFF_8000,
                              32'h0000_8000, 32'hFFFF_FF80, 32'h8000_F07F, 32'h0000_00F0};
  logic [31:0] t3_exp [3] = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333};

  initial begin
    bit acc;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_out_rd", 32'(out_rd), 32'd0);
    chk("rst_out_we", 32'(out_we), 32'd0);
    @(posedge clk); #1 rst = 1'b0;

    s0 = 32'h0000_1234;
    one(2'd0, 2'b10, 1'b0, 2'd0, 5'd3, 1'b1);
    chk("t1_valid", 32'(out_valid), 32'd1);
    chk("t1_data", out_data, 32'h0000_1234);
    chk("t1_rd", 32'(out_rd), 32'd3);
    chk("t1_we", 32'(out_we), 32'd1);

    s2 = 32'h8000_F07F;
    for (int i = 0; i < 8; i++) begin
      one(2'd2, t2_sz[i], t2_sg[i], t2_off[i], 5'd5, 1'b1);
      chk($sformatf("t2_load%0d", i), out_data, t2_exp[i]);
    end

    @(posedge clk); #1;
    out_ready = 1'b0; sel = 2'd0; size = 2'b10; we = 1'b1;
    s0 = t3_exp[0]; rd = 5'd1; in_valid = 1'b1;
    @(posedge clk); #1 s0 = t3_exp[1]; rd = 5'd2;
    @(posedge clk); #1 s0 = t3_exp[2]; rd = 5'd4;
    @(negedge clk);
    chk("t3_c_stall", 32'(in_ready), 32'd0);
    @(posedge clk); #1 out_ready = 1'b1; cap_en = 1'b1;
    acc = 1'b0;
    for (int i = 0; i < 8 && !acc; i++) begin
      @(negedge clk);
      if (in_ready) acc = 1'b1;
    end
    chk("t3_c_accept", 32'(acc), 32'd1);
    @(posedge clk); #1 in_valid = 1'b0;
    repeat (3) @(negedge clk);
    cap_en = 1'b0;
    chk("t3_count", 32'(seen.size()), 32'd3);
    for (int i = 0; i < seen.size() && i < 3; i++) chk($sformatf("t3_order%0d", i), seen[i], t3_exp[i]);

    s1 = 32'h0000_0104;
    one(2'd1, 2'b10, 1'b0, 2'd0, 5'd0, 1'b1);
    chk("t4_valid", 32'(out_valid), 32'd1);
    chk("t4_data", out_data, 32'h0000_0104);
    chk("t4_we", 32'(out_we), 32'd0);

    @(posedge clk); #1;
    out_ready = 1'b0; sel = 2'd0; s0 = 32'h55; rd = 5'd1; we = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1 s0 = 32'h66;
    @(posedge clk); #1 s0 = 32'h77; flush = 1'b1;
    @(negedge clk);
    chk("t5_flush_ready", 32'(in_ready), 32'd0);
    chk("t5_full_valid", 32'(out_valid), 32'd1);
    @(posedge clk); #1 flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("t5_empty", 32'(out_valid), 32'd0);
    chk("t5_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    chk("t5_dropped", 32'(out_valid), 32'd0);
    out_ready = 1'b1;

    s0 = 32'hAAAA_0001; s1 = 32'h0000_BBBB; s2 = 32'h0000_CCCC;
    one(2'd3, 2'b10, 1'b0, 2'd0, 5'd7, 1'b1);
    chk("t6_oor_sel", out_data, 32'hAAAA_0001);

    @(posedge clk); #1;
    out_ready = 1'b0; sel = 2'd0; s0 = 32'h99; rd = 5'd9; in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk("t6_rst_valid", 32'(out_valid), 32'd0);
    chk("t6_rst_data", out_data, 32'd0);
    chk("t6_rst_rd", 32'(out_rd), 32'd0);
    chk("t6_rst_we", 32'(out_we), 32'd0);
    @(posedge clk); #1 rst = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: run exceeded time limit, %0d/%0d passed", n_pass, n_chk);
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/wb_select_pipe.md
Name: wb_select_pipe

Overview:
Parametrised write-back stage for the KGP-RISC datapath. It selects one of NUM_SRC result sources (ALU, PC+4, load data, immediate, ...), size/sign-extends load data, and generates the register-file write enable. Results are registered in a 2-entry skid buffer with valid/ready handshakes on both sides, which decouples the MEM stage from register-file write timing.

Parameters:
DATA_W, 32, datapath width; must be >= 32.
NUM_SRC, 4, number of result sources; must be >= 2.
SEL_W, 2, select width; must equal ceil(log2(NUM_SRC)), minimum 1.
RA_W, 5, register address width.
MEM_SRC, 2, source index that carries raw load data and receives load extension.

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-high
flush  in  1  synchronous pipeline flush
in_valid  in  1  upstream result valid
in_ready  out  1  stage can accept
src_data  in  NUM_SRC*DATA_W  flattened sources; source k at bits [k*DATA_W +: DATA_W]
mem_to_reg  in  SEL_W  source select
ld_size  in  2  00 byte, 01 half, 10 word, 11 treated as word
ld_signed  in  1  1 = sign-extend, 0 = zero-extend
ld_off  in  2  byte offset of the load address
in_rd  in  RA_W  destination register
in_we  in  1  instruction writes a register
out_valid  out  1  registered result valid
out_ready  in  1  register file / downstream accepts
out_data  out  DATA_W  write-back data
out_rd  out  RA_W  destination register
out_we  out  1  register-file write enable

Behaviour:
- Clock and reset: single clock clk. rst is asynchronous and active-high. On reset: state EMPTY; out_valid, out_data, out_rd, out_we and skid contents = 0.
- Select: mem_to_reg < NUM_SRC picks that source. Out-of-range select picks source 0 (ALU).
- Load extension applies only when mem_to_reg == MEM_SRC, and only to the low 32 bits of that source:
  - byte: lane ld_off (bits [ld_off*8 +: 8]).
  - half: lane ld_off[1] (bits [ld_off[1]*16 +: 16]); ld_off[0] is ignored.
  - word: low 32 bits, unchanged.
  - The result is sign- or zero-extended to DATA_W per ld_signed.
- Write enable: stored we = in_we AND (in_rd != 0). Writes to r0 are suppressed, but the entry is still passed downstream with we = 0.
- Datapath order: select, extend and we are computed combinationally at input. The processed entry (data, rd, we) is stored.
- Handshake: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- in_ready = (state != FULL) & !flush. It depends only on registered state and flush, with no combinational path from out_ready.
- out_valid = (state != EMPTY). The out_* ports show the head entry.
- Latency: 1 cycle from in_fire into EMPTY to out_valid.
- Outputs are held stable while out_valid & !out_ready.
- State transitions:
  - EMPTY: in_fire -> load head, go to ONE.
  - ONE: in_fire & !out_fire -> load skid, go to FULL.
  - ONE: in_fire & out_fire -> load head with new entry, stay in ONE.
  - ONE: !in_fire & out_fire -> go to EMPTY.
  - FULL: out_fire -> head <= skid, go to ONE.
  - FULL: no in_fire is possible.
- Flush has highest priority: next state is EMPTY, both entries are invalidated, and a concurrent in_valid is dropped (in_ready is 0 during flush). A concurrent out_fire still completes in that cycle.
- Order is strictly FIFO and no entry is duplicated or lost, except on flush.
- Reset mid-stream discards all entries immediately (asynchronous).

Optional Feature:
Macro: WB_FWD_BYPASS_EN.
- Defined: adds output ports fwd_valid (1), fwd_rd (RA_W) and fwd_data (DATA_W), plus fwd_we (1).
  - They present the youngest valid stored entry: skid entry if FULL, head entry if ONE.
  - fwd_valid = 0 when EMPTY. All fwd_* ports reset to 0.
  - This is for the hazard/forwarding unit.
- Undefined: these ports and their logic do not exist. Core behaviour is identical.

Test Plan:
1. Reset then mem_to_reg=0, src0=0x0000_1234, in_rd=3, in_we=1, out_ready=1 -> next cycle out_valid=1, out_data=0x1234, out_rd=3, out_we=1.
2. mem_to_reg=MEM_SRC, src2=0x8000_F07F:
   - ld_size=00, ld_off=0, signed -> 0x0000_007F.
   - ld_off=1, signed -> 0xFFFF_FFF0.
   - half, ld_off=2, unsigned -> 0x0000_8000.
   - half, ld_off=2, signed -> 0xFFFF_8000.
3. out_ready=0, push 3 entries A, B, C back-to-back -> A and B accepted, in_ready=0 on C's cycle. Then out_ready=1 -> A, B, C emerge in order with no loss.
4. in_rd=0, in_we=1, mem_to_reg=1, src1=0x104 -> out_valid=1, out_data=0x104, out_we=0.
5. State FULL, assert flush with in_valid=1 and out_ready=0 -> next cycle out_valid=0, the input is not accepted, and in_ready=1 after flush deasserts.
6. Out-of-range select (NUM_SRC=3, mem_to_reg=3) -> src0 selected. Assert rst asynchronously mid-transfer -> all outputs 0 before the next clock edge.
